// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} sa_state_e;

  localparam int SA_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder_behavioral.sv
// Single-bit full adder cell: sum and carry-out of a + b + cin.
module full_adder_behavioral (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell per cycle, LSB first, with a carry flop between cycles.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

  sa_state_e        state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic             carry_q;
  logic [CntW-1:0]  cnt;
  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] s_next;

  full_adder_behavioral u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Sum bits enter at the MSB so the LSB computed first lands in bit 0 after WIDTH shifts.
  assign s_next = {fa_sum, s_sr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      s_sr    <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr    <= a;
            b_sr    <= b;
            carry_q <= cin;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          s_sr    <= s_next;
          carry_q <= fa_cout;
          if (cnt == CntMax) begin
            cnt   <= '0;
            sum   <= s_next;
            cout  <= fa_cout;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 (directed + random) and WIDTH=3 (exhaustive).
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0;
  logic       start3 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic [2:0] a3 = '0, b3 = '0;
  logic       cin3 = 1'b0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       busy3, done3, cout3;
  logic [2:0] sum3;

  int errors = 0;
  int checks = 0;
  logic [8:0] prev8 = '0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       c;
    bit         disturb;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder #(.WIDTH(3)) dut3 (
    .clk   (clk),
    .rst   (rst),
    .start (start3),
    .a     (a3),
    .b     (b3),
    .cin   (cin3),
    .busy  (busy3),
    .done  (done3),
    .sum   (sum3),
    .cout  (cout3)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // One WIDTH=8 operation observed over a fixed window; optionally disturbs inputs while busy.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                     input logic [7:0] es, input logic ec, input bit disturb, input string nm);
    int k, busy_n, done_n, done_at;
    @(negedge clk);
    a8 = ta; b8 = tb_; cin8 = tc; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    k = 1; busy_n = 0; done_n = 0; done_at = 0;
    chk({nm, " hold_on_start"}, {23'd0, cout8, sum8}, {23'd0, prev8});
    while (k <= 12) begin
      if (busy8) busy_n++;
      if (done8) begin
        done_n++;
        if (done_at == 0) done_at = k;
      end
      if (disturb && k >= 2 && k <= 8) begin
        start8 = (k % 2 == 0);
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    chk({nm, " latency"}, done_at, 9);
    chk({nm, " done_pulses"}, done_n, 1);
    chk({nm, " busy_cycles"}, busy_n, 9);
    chk({nm, " sum"}, {24'd0, sum8}, {24'd0, es});
    chk({nm, " cout"}, {31'd0, cout8}, {31'd0, ec});
    prev8 = {ec, es};
  endtask

  // One WIDTH=3 operation; returns in the done cycle so the next start lands in the first IDLE.
  task automatic op3(input logic [2:0] ta, input logic [2:0] tb_, input logic tc);
    int k;
    int e;
    @(negedge clk);
    a3 = ta; b3 = tb_; cin3 = tc; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    k = 1;
    while (!done3 && k < 10) begin
      @(negedge clk);
      k++;
    end
    e = int'(ta) + int'(tb_) + int'(tc);
    chk($sformatf("w3 latency a=%0d b=%0d c=%0d", ta, tb_, tc), k, 4);
    chk($sformatf("w3 result a=%0d b=%0d c=%0d", ta, tb_, tc), {28'd0, cout3, sum3}, e);
  endtask

  initial begin
    int dn;
    logic [8:0] m;
    vecs[0] = '{a: 8'h5A, b: 8'h33, cin: 1'b0, s: 8'h8D, c: 1'b0, disturb: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, s: 8'h00, c: 1'b1, disturb: 1'b0};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, s: 8'hFF, c: 1'b1, disturb: 1'b0};
    vecs[3] = '{a: 8'h3C, b: 8'hC5, cin: 1'b1, s: 8'h02, c: 1'b1, disturb: 1'b1};

    // Reset held with start asserted.
    start8 = 1'b1;
    start3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst busy", {31'd0, busy8}, 0);
      chk("rst done", {31'd0, done8}, 0);
      chk("rst sum_cout", {23'd0, cout8, sum8}, 0);
      chk("rst w3", {28'd0, busy3, done3, cout3, sum3[0]}, 0);
    end
    start8 = 1'b0;
    start3 = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      op8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].c, vecs[i].disturb,
          $sformatf("vec%0d", i));
    end

    // Reset during the 4th SHIFT cycle: no done, result cleared.
    @(negedge clk);
    a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst busy", {31'd0, busy8}, 0);
    chk("midrst done", {31'd0, done8}, 0);
    chk("midrst sum_cout", {23'd0, cout8, sum8}, 0);
    dn = 0;
    repeat (10) begin
      @(negedge clk);
      if (done8) dn++;
    end
    chk("midrst no_done", dn, 0);
    prev8 = '0;
    op8(8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0, "after_rst");

    // Random operands against plain integer addition.
    for (int i = 0; i < 20; i++) begin
      logic [7:0] ra, rb;
      logic rc;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      m = 9'(ra) + 9'(rb) + 9'(rc);
      op8(ra, rb, rc, m[7:0], m[8], (i % 4 == 0), $sformatf("rand%0d", i));
    end

    // WIDTH=3 exhaustive, back to back.
    for (int v = 0; v < 128; v++) begin
      logic [6:0] vv;
      vv = 7'(v);
      op3(vv[6:4], vv[3:1], vv[0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
